// File: rtl/chess_clock_pkg.sv
// rtl/chess_clock_pkg.sv - shared types and constants for the chess clock controller
package chess_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } clock_state_e;

    localparam logic TURN_WHITE = 1'b0;
    localparam logic TURN_BLACK = 1'b1;

endpackage

// File: rtl/chess_timer.sv
// rtl/chess_timer.sv - one player's countdown timer with load, decrement and optional saturating increment
//
// Purpose: holds the remaining ticks of one player. Load has priority over
// everything else; otherwise a decrement (never below 0) is applied first and
// then, when CHESS_CLOCK_INCREMENT_EN is defined, a saturating add of INC_TIME.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     synchronous active-low reset (reloads INIT_TIME)
//   load_i     synchronous reload of INIT_TIME
//   dec_i      decrement by one tick
//   inc_i      add INC_TIME, saturating (only with CHESS_CLOCK_INCREMENT_EN)
//   value_o    remaining ticks (registered)
//   is_one_o   value_o == 1
//   is_zero_o  value_o == 0
module chess_timer #(
    parameter int TIME_W    = 12,
    parameter int INIT_TIME = 600,
    parameter int INC_TIME  = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              dec_i,
`ifdef CHESS_CLOCK_INCREMENT_EN
    input  logic              inc_i,
`endif
    output logic [TIME_W-1:0] value_o,
    output logic              is_one_o,
    output logic              is_zero_o
);

    localparam logic [TIME_W-1:0] INIT_VAL = TIME_W'(INIT_TIME);

    logic [TIME_W-1:0] value_q;
    logic [TIME_W-1:0] value_d;

`ifdef CHESS_CLOCK_INCREMENT_EN
    localparam logic [TIME_W:0]   INC_VAL = (TIME_W+1)'(INC_TIME);
    localparam logic [TIME_W-1:0] MAX_VAL = {TIME_W{1'b1}};
    logic [TIME_W-1:0] dec_val;
    logic [TIME_W:0]   sum;

    always_comb begin
        dec_val = value_q;
        if (dec_i && (value_q != '0)) begin
            dec_val = value_q - 1'b1;
        end
        // One extra bit catches the carry so the add can saturate.
        sum     = {1'b0, dec_val} + INC_VAL;
        value_d = dec_val;
        if (inc_i) begin
            value_d = sum[TIME_W] ? MAX_VAL : sum[TIME_W-1:0];
        end
    end
`else
    always_comb begin
        value_d = value_q;
        if (dec_i && (value_q != '0)) begin
            value_d = value_q - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni || load_i) begin
            value_q <= INIT_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o   = value_q;
    assign is_one_o  = (value_q == TIME_W'(1));
    assign is_zero_o = (value_q == '0);

endmodule

// File: rtl/chess_clock_ctrl.sv
// rtl/chess_clock_ctrl.sv - two-player chess clock: turn bit, per-player timers, run/pause/timeout FSM
//
// Purpose: IDLE/RUN/PAUSED/OVER state machine controlling two chess_timer
// instances and the side-to-move bit. Optional feature macro:
// CHESS_CLOCK_INCREMENT_EN adds INC_TIME to the mover's timer on each honoured move.
// Ports:
//   CLK, RESET_N              clock and synchronous active-low reset
//   START                     pulse: IDLE->RUN, OVER->IDLE
//   PAUSE                     level: pause while high in RUN/PAUSED
//   TICK                      one-tick time strobe
//   BTN_W, BTN_B              end-of-move pulses
//   TIME_W_OUT, TIME_B_OUT    remaining ticks per player
//   TURN                      0 = white to move, 1 = black to move
//   STATE                     IDLE=0, RUN=1, PAUSED=2, OVER=3
//   FLAG_W, FLAG_B            sticky timeout flags
module chess_clock_ctrl
    import chess_clock_pkg::*;
#(
    parameter int TIME_W    = 12,
    parameter int INIT_TIME = 600,
    parameter int INC_TIME  = 5
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic              PAUSE,
    input  logic              TICK,
    input  logic              BTN_W,
    input  logic              BTN_B,
    output logic [TIME_W-1:0] TIME_W_OUT,
    output logic [TIME_W-1:0] TIME_B_OUT,
    output logic              TURN,
    output logic [1:0]        STATE,
    output logic              FLAG_W,
    output logic              FLAG_B
);

    clock_state_e state_q, state_d;
    logic         turn_q, turn_d;
    logic         flag_w_q, flag_w_d;
    logic         flag_b_q, flag_b_d;

    logic load;
    logic dec_w, dec_b;
    logic inc_w, inc_b;
    logic w_is_one, b_is_one;
    logic w_is_zero, b_is_zero;
    logic active_is_one;
    logic active_btn;

    // Only the side to move can end a move or run out of time.
    assign active_is_one = (turn_q == TURN_BLACK) ? b_is_one : w_is_one;
    assign active_btn    = (turn_q == TURN_BLACK) ? BTN_B    : BTN_W;

    always_comb begin
        state_d  = state_q;
        turn_d   = turn_q;
        flag_w_d = flag_w_q;
        flag_b_d = flag_b_q;
        load     = 1'b0;
        dec_w    = 1'b0;
        dec_b    = 1'b0;
        inc_w    = 1'b0;
        inc_b    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                load   = 1'b1;
                turn_d = TURN_WHITE;
                if (START) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (PAUSE) begin
                    state_d = ST_PAUSED;
                end else if (TICK && active_is_one) begin
                    // Timeout wins over a same-cycle move.
                    state_d = ST_OVER;
                    if (turn_q == TURN_BLACK) begin
                        dec_b    = 1'b1;
                        flag_b_d = 1'b1;
                    end else begin
                        dec_w    = 1'b1;
                        flag_w_d = 1'b1;
                    end
                end else begin
                    if (turn_q == TURN_BLACK) begin
                        dec_b = TICK;
                        inc_b = active_btn;
                    end else begin
                        dec_w = TICK;
                        inc_w = active_btn;
                    end
                    if (active_btn) begin
                        turn_d = ~turn_q;
                    end
                end
            end
            ST_PAUSED: begin
                if (!PAUSE) begin
                    state_d = ST_RUN;
                end
            end
            ST_OVER: begin
                if (START) begin
                    state_d  = ST_IDLE;
                    load     = 1'b1;
                    turn_d   = TURN_WHITE;
                    flag_w_d = 1'b0;
                    flag_b_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            turn_q   <= TURN_WHITE;
            flag_w_q <= 1'b0;
            flag_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            flag_w_q <= flag_w_d;
            flag_b_q <= flag_b_d;
        end
    end

    chess_timer #(
        .TIME_W    (TIME_W),
        .INIT_TIME (INIT_TIME),
        .INC_TIME  (INC_TIME)
    ) u_timer_w (
        .clk_i     (CLK),
        .rst_ni    (RESET_N),
        .load_i    (load),
        .dec_i     (dec_w),
`ifdef CHESS_CLOCK_INCREMENT_EN
        .inc_i     (inc_w),
`endif
        .value_o   (TIME_W_OUT),
        .is_one_o  (w_is_one),
        .is_zero_o (w_is_zero)
    );

    chess_timer #(
        .TIME_W    (TIME_W),
        .INIT_TIME (INIT_TIME),
        .INC_TIME  (INC_TIME)
    ) u_timer_b (
        .clk_i     (CLK),
        .rst_ni    (RESET_N),
        .load_i    (load),
        .dec_i     (dec_b),
`ifdef CHESS_CLOCK_INCREMENT_EN
        .inc_i     (inc_b),
`endif
        .value_o   (TIME_B_OUT),
        .is_one_o  (b_is_one),
        .is_zero_o (b_is_zero)
    );

`ifndef CHESS_CLOCK_INCREMENT_EN
    // Increment requests have no consumer when the feature is not built.
    logic unused_inc;
    assign unused_inc = inc_w ^ inc_b;
`endif
    // Zero is only reached on the timeout transition, which is decided via is_one.
    logic unused_zero;
    assign unused_zero = w_is_zero ^ b_is_zero;

    assign TURN   = turn_q;
    assign STATE  = state_q;
    assign FLAG_W = flag_w_q;
    assign FLAG_B = flag_b_q;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// tb/tb_chess_clock_ctrl.sv - directed self-checking bench for chess_clock_ctrl
module tb_chess_clock_ctrl;

    logic CLK = 1'b0;
    logic RESET_N, START, PAUSE, TICK, BTN_W, BTN_B;

    logic [11:0] tw, tb;
    logic        turn, fw, fb;
    logic [1:0]  st;

    logic [11:0] tw2, tb2;
    logic        turn2, fw2, fb2;
    logic [1:0]  st2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    chess_clock_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .PAUSE(PAUSE), .TICK(TICK),
        .BTN_W(BTN_W), .BTN_B(BTN_B), .TIME_W_OUT(tw), .TIME_B_OUT(tb),
        .TURN(turn), .STATE(st), .FLAG_W(fw), .FLAG_B(fb)
    );

    chess_clock_ctrl #(.INIT_TIME(2)) dut2 (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .PAUSE(PAUSE), .TICK(TICK),
        .BTN_W(BTN_W), .BTN_B(BTN_B), .TIME_W_OUT(tw2), .TIME_B_OUT(tb2),
        .TURN(turn2), .STATE(st2), .FLAG_W(fw2), .FLAG_B(fb2)
    );

`ifdef CHESS_CLOCK_INCREMENT_EN
    logic [3:0] tw3, tb3;
    logic       turn3, fw3, fb3;
    logic [1:0] st3;

    chess_clock_ctrl #(.TIME_W(4), .INIT_TIME(14), .INC_TIME(5)) dut3 (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .PAUSE(PAUSE), .TICK(TICK),
        .BTN_W(BTN_W), .BTN_B(BTN_B), .TIME_W_OUT(tw3), .TIME_B_OUT(tb3),
        .TURN(turn3), .STATE(st3), .FLAG_W(fw3), .FLAG_B(fb3)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply the current inputs for one edge, then clear all pulses.
    task automatic cyc();
        @(posedge CLK);
        #1;
        START = 1'b0;
        TICK  = 1'b0;
        BTN_W = 1'b0;
        BTN_B = 1'b0;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        cyc();
        RESET_N = 1'b1;
    endtask

    initial begin
        RESET_N = 1'b0; START = 1'b0; PAUSE = 1'b0; TICK = 1'b0; BTN_W = 1'b0; BTN_B = 1'b0;
        cyc();
        cyc();
        RESET_N = 1'b1;

        check("rst_state", st, 0);
        check("rst_tw", tw, 600);
        check("rst_tb", tb, 600);
        check("rst_turn", turn, 0);
        check("rst_flags", {fw, fb}, 0);
        cyc();
        check("idle_tick_ignored", tw, 600);

        // Timeout with INIT_TIME=2 (dut2)
        START = 1'b1; cyc();
        check("t4_run", st2, 1);
        TICK = 1'b1; cyc();
        check("t4_tw_1", tw2, 1);
        TICK = 1'b1; BTN_W = 1'b1; cyc();
        check("t4_tw_0", tw2, 0);
        check("t4_flag_w", fw2, 1);
        check("t4_flag_b", fb2, 0);
        check("t4_over", st2, 3);
        check("t4_turn", turn2, 0);
        check("t4_tb", tb2, 2);
        TICK = 1'b1; cyc();
        check("t4_frozen", tw2, 0);
        START = 1'b1; cyc();
        check("t4_rearm_state", st2, 0);
        check("t4_rearm_tw", tw2, 2);
        check("t4_rearm_flag", fw2, 0);

        // Reset mid-RUN
        do_reset();
        START = 1'b1; cyc();
        for (int i = 0; i < 10; i++) begin
            TICK = 1'b1; cyc();
        end
        BTN_W = 1'b1; cyc();
        check("t1_pre_tw", tw, 590);
        check("t1_pre_turn", turn, 1);
        RESET_N = 1'b0; cyc();
        RESET_N = 1'b1;
        check("t1_state", st, 0);
        check("t1_tw", tw, 600);
        check("t1_tb", tb, 600);
        check("t1_turn", turn, 0);
        check("t1_flags", {fw, fb}, 0);

        // START, ticks, moves
        START = 1'b1; cyc();
        check("t2_run", st, 1);
        for (int i = 0; i < 3; i++) begin
            TICK = 1'b1; cyc();
        end
        check("t2_tw", tw, 597);
        check("t2_tb", tb, 600);
        BTN_W = 1'b1; cyc();
        check("t2_turn_b", turn, 1);
        BTN_W = 1'b1; cyc();
        check("t2_inactive_btn", turn, 1);
        TICK = 1'b1; cyc();
        check("t2_tb_dec", tb, 599);
        check("t2_tw_hold", tw, 597);
        BTN_B = 1'b1; cyc();
        check("t2_turn_w", turn, 0);

        // Both buttons plus tick while white to move
        BTN_W = 1'b1; BTN_B = 1'b1; TICK = 1'b1; cyc();
        check("t3_tw", tw, 596);
        check("t3_tb", tb, 599);
        check("t3_turn", turn, 1);

        START = 1'b1; cyc();
        check("start_in_run", st, 1);

        // Pause window
        PAUSE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            TICK  = (i % 2 == 1) && (i < 9);
            BTN_B = (i == 4);
            cyc();
            if (i == 0) check("t5_paused", st, 2);
        end
        check("t5_tw", tw, 596);
        check("t5_tb", tb, 599);
        check("t5_turn", turn, 1);
        check("t5_state", st, 2);
        PAUSE = 1'b0; cyc();
        check("t5_resume", st, 1);
        TICK = 1'b1; cyc();
        check("t5_tb_after", tb, 598);

`ifdef CHESS_CLOCK_INCREMENT_EN
        do_reset();
        START = 1'b1; cyc();
        BTN_W = 1'b1; cyc();
        check("t6_sat", tw3, 15);
        check("t6_turn", turn3, 1);
        check("t6_inc_600", tw, 605);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
